core_control: RTL and testbench
===============================

# core_control

Multi-cycle sequencing FSM for the RV32I core. Drives the fetch/decode/execute/memory/writeback sequence around the instruction decoder, ALU, register file and shared memory port. Owns the instruction-register load, PC update select, register-file write enable, trap entry and (optionally) debug halt. One instruction in flight at a time; no pipelining.

## Interface
- No parameters; widths come from `isa.svh` (`ISA__OPCODE_WIDTH` = 7).
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  `ISA__OPCODE_WIDTH`  decoded opcode of current IR
- invalid_inst  in  1  decoder illegal-instruction flag
- ecall  in  1  decoder ECALL flag
- ebreak  in  1  decoder EBREAK flag
- branch_taken  in  1  ALU comparator result for BRANCH
- mem_ack  in  1  memory port completion, single-cycle pulse
- haltreq  in  1  debug halt request (level)
- resumereq  in  1  debug resume request (level)
- mem_req  out  1  memory port request
- mem_fetch  out  1  1 = instruction fetch (addr = PC), 0 = data access (addr = ALU result)
- mem_we  out  1  store access
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  update PC
- pc_sel  out  2  0 = PC+4, 1 = ALU target (JAL/JALR/taken branch), 2 = trap vector
- rf_we  out  1  register-file write
- trap  out  1  trap-entry pulse
- trap_cause  out  4  2 illegal, 3 breakpoint, 11 ECALL; valid while trap=1
- retire  out  1  instruction-retired pulse
- halted  out  1  core in debug halt

## Operation
- States: RESET, FETCH, DECODE, EXECUTE, MEM, WB, TRAP, HALT. Outputs are decoded from state (Moore) except where noted.
- RESET: all outputs 0; next FETCH.
- FETCH: mem_req=1, mem_fetch=1, mem_we=0. On mem_ack: ir_we=1 (same cycle, Mealy) and go to DECODE; else stay.
- DECODE: decoder evaluates IR. invalid_inst → TRAP cause 2; ecall → TRAP cause 11; ebreak → TRAP cause 3, or HALT when the macro is on; otherwise → EXECUTE. Priority: invalid_inst > ecall > ebreak.
- EXECUTE: LOAD/STORE → MEM. All other opcodes → WB.
- MEM: mem_req=1, mem_fetch=0, mem_we=1 for STORE. Hold until mem_ack, then → WB.
- WB:
  - rf_we=1 for LUI, AUIPC, JAL, JALR, OPIMM, OP, LOAD, SYSTEM (CSR).
  - rf_we=0 for BRANCH, STORE, MISCMEM.
  - pc_we=1. pc_sel=1 for JAL, JALR, or BRANCH with branch_taken=1; else 0.
  - retire=1. Next FETCH (or HALT, see Configuration).
- TRAP: trap=1, trap_cause latched in DECODE, pc_we=1, pc_sel=2, retire=0. Next FETCH (or HALT).
- HALT: halted=1, all other outputs 0. resumereq=1 → FETCH.
- mem_req, mem_fetch and mem_we stay stable from assertion until the mem_ack cycle inclusive. mem_ack outside FETCH/MEM is ignored.
- rst=1 in any state, including mid memory request: next state RESET and mem_req drops the following cycle. Memory must tolerate an abandoned request.

## Timing
- Zero-wait memory (ack in the request cycle):
  - ALU/branch/jump: 4 cycles (FETCH, DECODE, EXECUTE, WB).
  - Load/store: 5 cycles.
  - Trap: 3 cycles (FETCH, DECODE, TRAP).
- Each memory wait cycle adds 1 cycle.
- After rst deasserts: one cycle in RESET, then mem_req=1 in the next cycle.
- ir_we asserts in the mem_ack cycle of FETCH. IR is valid to the decoder from the DECODE cycle onward.
- trap_cause register reset value is 0. It is updated only on the DECODE→TRAP transition.

## Configuration
- DEBUG_HALT_EN defined:
  - EBREAK enters HALT instead of trapping.
  - haltreq sampled in WB and TRAP only (instruction boundary): if 1, next state is HALT instead of FETCH. The PC update in that WB/TRAP cycle still happens.
  - HALT exits to FETCH on resumereq.
  - If haltreq and resumereq are both high in HALT, resume wins. If they are still held, the core re-halts at the next boundary.
- DEBUG_HALT_EN undefined:
  - HALT state absent; halted tied 0.
  - haltreq and resumereq ignored.
  - EBREAK traps with cause 3.

## Test plan
- ADDI x1,x0,5, zero-wait memory → mem_req cycle 1 after RESET; rf_we, pc_we (pc_sel=0), retire in cycle 4; next mem_req cycle 5.
- LW with mem_ack delayed 3 cycles in both FETCH and MEM → retire at cycle 11; mem_fetch=1 in FETCH and 0 in MEM; signals stable throughout each wait.
- BEQ with branch_taken=1, then with branch_taken=0 → pc_sel=1 then 0; rf_we=0 both times.
- Illegal word 0x00000000, then ECALL → trap=1 with cause 2, then cause 11; pc_sel=2, retire=0, rf_we=0.
- EBREAK → with DEBUG_HALT_EN: halted=1 until resumereq, then mem_req next cycle. Without: trap cause 3. With the macro, haltreq held during an ADD → halt entered after WB.
- rst asserted in the 2nd wait cycle of FETCH → RESET next cycle, all outputs 0; clean refetch afterwards.

Source files
------------

// File: rtl/core_control.sv
`timescale 1ns/1ps
// core_control: multi-cycle RV32I sequencer (fetch/decode/execute/mem/writeback, traps).
// Define DEBUG_HALT_EN to add the debug HALT state (EBREAK halts, haltreq/resumereq honoured).
`ifndef ISA__OPCODE_WIDTH
`define ISA__OPCODE_WIDTH 7
`endif

// state   | meaning
// RESET   | post-reset idle cycle, all outputs low
// FETCH   | instruction fetch at PC, IR loads on mem_ack
// DECODE  | decoder evaluates IR, trap causes resolved
// EXECUTE | ALU cycle, selects MEM or WB
// MEM     | data load/store, held until mem_ack
// WB      | register write, PC update, retire
// TRAP    | PC to trap vector, cause presented
// HALT    | debug halt (DEBUG_HALT_EN only)
module core_control (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [`ISA__OPCODE_WIDTH-1:0] opcode,
  input  logic                          invalid_inst,
  input  logic                          ecall,
  input  logic                          ebreak,
  input  logic                          branch_taken,
  input  logic                          mem_ack,
  input  logic                          haltreq,
  input  logic                          resumereq,
  output logic                          mem_req,
  output logic                          mem_fetch,
  output logic                          mem_we,
  output logic                          ir_we,
  output logic                          pc_we,
  output logic [1:0]                    pc_sel,
  output logic                          rf_we,
  output logic                          trap,
  output logic [3:0]                    trap_cause,
  output logic                          retire,
  output logic                          halted
);

  localparam int OW = `ISA__OPCODE_WIDTH;

  localparam logic [OW-1:0] OP_LUI     = 7'b0110111;
  localparam logic [OW-1:0] OP_AUIPC   = 7'b0010111;
  localparam logic [OW-1:0] OP_JAL     = 7'b1101111;
  localparam logic [OW-1:0] OP_JALR    = 7'b1100111;
  localparam logic [OW-1:0] OP_BRANCH  = 7'b1100011;
  localparam logic [OW-1:0] OP_LOAD    = 7'b0000011;
  localparam logic [OW-1:0] OP_STORE   = 7'b0100011;
  localparam logic [OW-1:0] OP_OPIMM   = 7'b0010011;
  localparam logic [OW-1:0] OP_OP      = 7'b0110011;
  localparam logic [OW-1:0] OP_SYSTEM  = 7'b1110011;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_BREAK   = 4'd3;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_ALU   = 2'd1;
  localparam logic [1:0] PC_TRAP  = 2'd2;

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
`ifdef DEBUG_HALT_EN
    S_TRAP    = 3'd6,
    S_HALT    = 3'd7
`else
    S_TRAP    = 3'd6
`endif
  } state_t;

  state_t     state, state_next;
  logic [3:0] cause_q;
  logic [3:0] decode_cause;
  state_t     boundary_next;
  logic       is_mem_op;

  assign is_mem_op = (opcode == OP_LOAD) || (opcode == OP_STORE);

  // Priority invalid > ecall > ebreak; only consulted when one of them is set.
  assign decode_cause = invalid_inst ? CAUSE_ILLEGAL :
                        ecall        ? CAUSE_ECALL   : CAUSE_BREAK;

`ifdef DEBUG_HALT_EN
  assign boundary_next = haltreq ? S_HALT : S_FETCH;
`else
  assign boundary_next = S_FETCH;
  logic unused_dbg;
  assign unused_dbg = haltreq ^ resumereq;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RESET;
      cause_q <= 4'd0;
    end else begin
      state <= state_next;
      if (state == S_DECODE && state_next == S_TRAP)
        cause_q <= decode_cause;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RESET:   state_next = S_FETCH;
      S_FETCH:   if (mem_ack) state_next = S_DECODE;
      S_DECODE: begin
        if (invalid_inst || ecall)
          state_next = S_TRAP;
        else if (ebreak)
`ifdef DEBUG_HALT_EN
          state_next = S_HALT;
`else
          state_next = S_TRAP;
`endif
        else
          state_next = S_EXECUTE;
      end
      S_EXECUTE: state_next = is_mem_op ? S_MEM : S_WB;
      S_MEM:     if (mem_ack) state_next = S_WB;
      S_WB:      state_next = boundary_next;
      S_TRAP:    state_next = boundary_next;
`ifdef DEBUG_HALT_EN
      S_HALT:    if (resumereq) state_next = S_FETCH;
`endif
      default:   state_next = S_RESET;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_fetch = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    rf_we     = 1'b0;
    trap      = 1'b0;
    retire    = 1'b0;
    halted    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        mem_fetch = 1'b1;
        ir_we     = mem_ack;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (opcode == OP_STORE);
      end
      S_WB: begin
        pc_we  = 1'b1;
        retire = 1'b1;
        case (opcode)
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
          OP_OPIMM, OP_OP, OP_LOAD, OP_SYSTEM: rf_we = 1'b1;
          default:                             rf_we = 1'b0;
        endcase
        if (opcode == OP_JAL || opcode == OP_JALR ||
            (opcode == OP_BRANCH && branch_taken))
          pc_sel = PC_ALU;
      end
      S_TRAP: begin
        trap   = 1'b1;
        pc_we  = 1'b1;
        pc_sel = PC_TRAP;
      end
`ifdef DEBUG_HALT_EN
      S_HALT: halted = 1'b1;
`endif
      default: ;
    endcase
  end

  assign trap_cause = cause_q;

endmodule

// File: tb/tb_core_control.sv
`timescale 1ns/1ps
// Self-checking bench for core_control: scoreboarded PC-update events plus cycle/handshake checks.
module tb_core_control;

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_OPIMM   = 7'b0010011;
  localparam logic [6:0] OP_OP      = 7'b0110011;
  localparam logic [6:0] OP_MISCMEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       invalid_inst = 1'b0, ecall = 1'b0, ebreak = 1'b0, branch_taken = 1'b0;
  logic       mem_ack = 1'b0, haltreq = 1'b0, resumereq = 1'b0;
  logic       mem_req, mem_fetch, mem_we, ir_we, pc_we, rf_we, trap, retire, halted;
  logic [1:0] pc_sel;
  logic [3:0] trap_cause;

  core_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .invalid_inst(invalid_inst), .ecall(ecall),
    .ebreak(ebreak), .branch_taken(branch_taken), .mem_ack(mem_ack), .haltreq(haltreq),
    .resumereq(resumereq), .mem_req(mem_req), .mem_fetch(mem_fetch), .mem_we(mem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .trap(trap),
    .trap_cause(trap_cause), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  wire [14:0] outs = {mem_req, mem_fetch, mem_we, ir_we, pc_we, pc_sel, rf_we, trap,
                      trap_cause, retire, halted};

  typedef struct {
    int         cyc;
    logic       rf_we;
    logic [1:0] pc_sel;
    logic       trap;
    logic [3:0] cause;
    logic       retire;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  int   pass_cnt = 0, total_cnt = 0;
  int   cyc = 0, f_wait = 0, m_wait = 0, wait_cnt = 0, stab_err = 0;
  int   run_ffetch = -1, run_irwe = 0, run_irwe_cyc = -1;
  bit   req_active = 0, run_data = 0, run_we = 0;
  logic [1:0] req_attr = 2'b00;
  logic [3:0] model_cause = 4'd0;

  // One clock: memory responder acts on the falling edge, outputs sampled 1ns later.
  task automatic tick();
    ev_t o;
    @(negedge clk);
    mem_ack = 1'b0;
    if (mem_req !== 1'b1) req_active = 0;
    else begin
      if (!req_active) begin
        req_active = 1;
        wait_cnt   = mem_fetch ? f_wait : m_wait;
        req_attr   = {mem_fetch, mem_we};
      end else if ({mem_fetch, mem_we} !== req_attr) stab_err++;
      if (wait_cnt == 0) mem_ack = 1'b1;
      else wait_cnt--;
    end
    #1;
    cyc++;
    if (mem_req === 1'b1 && mem_fetch === 1'b1 && run_ffetch < 0) run_ffetch = cyc;
    if (mem_req === 1'b1 && mem_fetch === 1'b0) run_data = 1;
    if (mem_we === 1'b1) run_we = 1;
    if (ir_we === 1'b1) begin run_irwe++; run_irwe_cyc = cyc; end
    if (mem_ack) req_active = 0;
    if (pc_we === 1'b1) begin
      o.cyc = cyc; o.rf_we = rf_we; o.pc_sel = pc_sel; o.trap = trap;
      o.cause = trap_cause; o.retire = retire;
      obs_q.push_back(o);
    end
  endtask

  // Reference: expected PC-update event for one instruction, starting from the current cycle.
  function automatic ev_t model_ev(logic [6:0] opc, bit inv, bit ec, bit eb, bit bt, int fw, int mw);
    ev_t e;
    bit  mem_op;
    if (inv || ec || eb) begin
      model_cause = inv ? 4'd2 : (ec ? 4'd11 : 4'd3);
      e.cyc = cyc + fw + 3; e.rf_we = 0; e.pc_sel = 2'd2; e.trap = 1; e.retire = 0;
    end else begin
      mem_op = (opc == OP_LOAD) || (opc == OP_STORE);
      e.cyc = cyc + fw + 4 + (mem_op ? 1 + mw : 0);
      e.rf_we = !(opc == OP_BRANCH || opc == OP_STORE || opc == OP_MISCMEM);
      e.pc_sel = (opc == OP_JAL || opc == OP_JALR || (opc == OP_BRANCH && bt)) ? 2'd1 : 2'd0;
      e.trap = 0; e.retire = 1;
    end
    e.cause = model_cause;
    return e;
  endfunction

  task automatic run_inst(input logic [6:0] opc, input bit inv, input bit ec, input bit eb,
                          input bit bt, input int fw, input int mw);
    int n0, guard;
    n0 = obs_q.size(); guard = 0;
    opcode = opc; invalid_inst = inv; ecall = ec; ebreak = eb; branch_taken = bt;
    f_wait = fw; m_wait = mw;
    run_ffetch = -1; run_irwe = 0; run_irwe_cyc = -1; run_data = 0; run_we = 0;
    do begin
      tick();
      guard++;
    end while (obs_q.size() == n0 && halted !== 1'b1 && guard < 60);
    if (guard >= 60) begin
      total_cnt++;
      $display("FAIL run_timeout: no pc_we or halt after %0d cycles, required within 60", guard);
    end
  endtask

  task automatic issue(input logic [6:0] opc, input bit inv, input bit ec, input bit eb,
                       input bit bt, input int fw, input int mw);
    exp_q.push_back(model_ev(opc, inv, ec, eb, bt, fw, mw));
    run_inst(opc, inv, ec, eb, bt, fw, mw);
  endtask

  task automatic take(output ev_t e, output ev_t o);
    e = exp_q.pop_front();
    if (obs_q.size() > 0) o = obs_q.pop_front();
    else begin
      o.cyc = -1; o.rf_we = 'x; o.pc_sel = 'x; o.trap = 'x; o.cause = 'x; o.retire = 'x;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total_cnt++;
    if (outs !== 15'd0) $display("FAIL reset_held: outputs %b, expected all 0", outs);
    else pass_cnt++;
    rst = 1'b0;
    cyc = 0;
    total_cnt++;
    if (outs !== 15'd0) $display("FAIL reset_release: outputs %b, expected all 0", outs);
    else pass_cnt++;
  endtask

  task automatic test_alu();
    ev_t e, o;
    int  base;
    base = cyc;
    issue(OP_OPIMM, 0, 0, 0, 0, 0, 0);
    take(e, o);
    total_cnt++;
    if (run_ffetch !== base + 1) $display("FAIL alu_first_req: cycle %0d, expected %0d", run_ffetch, base + 1);
    else pass_cnt++;
    total_cnt++;
    if (run_irwe_cyc !== base + 1) $display("FAIL alu_ir_we: cycle %0d, expected %0d", run_irwe_cyc, base + 1);
    else pass_cnt++;
    total_cnt++;
    if (o.cyc !== e.cyc) $display("FAIL alu_wb_cycle: cycle %0d, expected %0d", o.cyc, e.cyc);
    else pass_cnt++;
    total_cnt++;
    if ({o.rf_we, o.pc_sel, o.trap, o.cause, o.retire} !== {e.rf_we, e.pc_sel, e.trap, e.cause, e.retire})
      $display("FAIL alu_wb_fields: got %b, expected %b",
               {o.rf_we, o.pc_sel, o.trap, o.cause, o.retire}, {e.rf_we, e.pc_sel, e.trap, e.cause, e.retire});
    else pass_cnt++;
  endtask

  task automatic test_load_wait();
    ev_t e, o;
    int  base, s0;
    base = cyc; s0 = stab_err;
    issue(OP_LOAD, 0, 0, 0, 0, 3, 3);
    take(e, o);
    total_cnt++;
    if (run_ffetch !== base + 1) $display("FAIL lw_first_req: cycle %0d, expected %0d", run_ffetch, base + 1);
    else pass_cnt++;
    total_cnt++;
    if (run_irwe !== 1 || run_irwe_cyc !== base + 4)
      $display("FAIL lw_ir_we: %0d pulses at cycle %0d, expected 1 at %0d", run_irwe, run_irwe_cyc, base + 4);
    else pass_cnt++;
    total_cnt++;
    if (o.cyc !== e.cyc) $display("FAIL lw_wb_cycle: cycle %0d, expected %0d", o.cyc, e.cyc);
    else pass_cnt++;
    total_cnt++;
    if ({o.rf_we, o.pc_sel, o.trap, o.cause, o.retire} !== {e.rf_we, e.pc_sel, e.trap, e.cause, e.retire})
      $display("FAIL lw_wb_fields: got %b, expected %b",
               {o.rf_we, o.pc_sel, o.trap, o.cause, o.retire}, {e.rf_we, e.pc_sel, e.trap, e.cause, e.retire});
    else pass_cnt++;
    total_cnt++;
    if ({run_data, run_we} !== 2'b10) $display("FAIL lw_data_access: data/we %b, expected 10", {run_data, run_we});
    else pass_cnt++;
    total_cnt++;
    if (stab_err !== s0) $display("FAIL lw_req_stable: %0d changes, expected 0", stab_err - s0);
    else pass_cnt++;
  endtask

  task automatic test_store();
    ev_t e, o;
    issue(OP_STORE, 0, 0, 0, 0, 0, 1);
    take(e, o);
    total_cnt++;
    if (run_we !== 1'b1) $display("FAIL sw_mem_we: %b, expected 1", run_we);
    else pass_cnt++;
    total_cnt++;
    if (o.cyc !== e.cyc) $display("FAIL sw_wb_cycle: cycle %0d, expected %0d", o.cyc, e.cyc);
    else pass_cnt++;
    total_cnt++;
    if ({o.rf_we, o.pc_sel, o.trap, o.cause, o.retire} !== {e.rf_we, e.pc_sel, e.trap, e.cause, e.retire})
      $display("FAIL sw_wb_fields: got %b, expected %b",
               {o.rf_we, o.pc_sel, o.trap, o.cause, o.retire}, {e.rf_we, e.pc_sel, e.trap, e.cause, e.retire});
    else pass_cnt++;
  endtask

  task automatic test_branch_jump();
    ev_t e, o;
    issue(OP_BRANCH, 0, 0, 0, 1, 0, 0);
    issue(OP_BRANCH, 0, 0, 0, 0, 1, 0);
    issue(OP_JAL,    0, 0, 0, 0, 0, 0);
    issue(OP_JALR,   0, 0, 0, 1, 2, 0);
    issue(OP_MISCMEM, 0, 0, 0, 1, 0, 0);
    issue(OP_LUI,    0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      take(e, o);
      total_cnt++;
      if (o.cyc !== e.cyc || {o.rf_we, o.pc_sel, o.trap, o.cause, o.retire} !== {e.rf_we, e.pc_sel, e.trap, e.cause, e.retire})
        $display("FAIL flow_%0d: cycle %0d fields %b, expected cycle %0d fields %b", i, o.cyc,
                 {o.rf_we, o.pc_sel, o.trap, o.cause, o.retire}, e.cyc, {e.rf_we, e.pc_sel, e.trap, e.cause, e.retire});
      else pass_cnt++;
    end
  endtask

  task automatic test_traps();
    ev_t e, o;
    issue(7'd0,      1, 0, 0, 0, 0, 0);
    issue(OP_SYSTEM, 0, 1, 0, 0, 1, 0);
    issue(OP_SYSTEM, 1, 1, 1, 0, 0, 0);
    issue(OP_SYSTEM, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      take(e, o);
      total_cnt++;
      if (o.cyc !== e.cyc) $display("FAIL trap_%0d_cycle: cycle %0d, expected %0d", i, o.cyc, e.cyc);
      else pass_cnt++;
      total_cnt++;
      if ({o.rf_we, o.pc_sel, o.trap, o.cause, o.retire} !== {e.rf_we, e.pc_sel, e.trap, e.cause, e.retire})
        $display("FAIL trap_%0d_fields: got %b, expected %b", i,
                 {o.rf_we, o.pc_sel, o.trap, o.cause, o.retire}, {e.rf_we, e.pc_sel, e.trap, e.cause, e.retire});
      else pass_cnt++;
    end
  endtask

  task automatic test_ebreak();
    ev_t e, o;
`ifdef DEBUG_HALT_EN
    int n0, base;
    n0 = obs_q.size();
    run_inst(OP_SYSTEM, 0, 0, 1, 0, 0, 0);
    total_cnt++;
    if (halted !== 1'b1 || obs_q.size() !== n0)
      $display("FAIL ebreak_halt: halted %b events %0d, expected halted 1 events %0d", halted, obs_q.size(), n0);
    else pass_cnt++;
    ebreak = 1'b0;
    tick(); tick();
    total_cnt++;
    if (outs !== 15'b000000000_0000_01 && outs !== {9'd0, model_cause, 2'b01})
      $display("FAIL ebreak_hold: outputs %b, expected only halted", outs);
    else pass_cnt++;
    base = cyc;
    resumereq = 1'b1;
    issue(OP_OP, 0, 0, 0, 0, 0, 0);
    resumereq = 1'b0;
    take(e, o);
    total_cnt++;
    if (run_ffetch !== base + 1) $display("FAIL ebreak_resume: fetch cycle %0d, expected %0d", run_ffetch, base + 1);
    else pass_cnt++;
    total_cnt++;
    if (o.cyc !== e.cyc) $display("FAIL ebreak_next_wb: cycle %0d, expected %0d", o.cyc, e.cyc);
    else pass_cnt++;
`else
    issue(OP_SYSTEM, 0, 0, 1, 0, 0, 0);
    take(e, o);
    total_cnt++;
    if (o.cyc !== e.cyc) $display("FAIL ebreak_cycle: cycle %0d, expected %0d", o.cyc, e.cyc);
    else pass_cnt++;
    total_cnt++;
    if ({o.rf_we, o.pc_sel, o.trap, o.cause, o.retire} !== {e.rf_we, e.pc_sel, e.trap, e.cause, e.retire})
      $display("FAIL ebreak_fields: got %b, expected %b",
               {o.rf_we, o.pc_sel, o.trap, o.cause, o.retire}, {e.rf_we, e.pc_sel, e.trap, e.cause, e.retire});
    else pass_cnt++;
`endif
  endtask

  task automatic test_halt_request();
`ifdef DEBUG_HALT_EN
    ev_t e, o;
    int  base;
    haltreq = 1'b1;
    issue(OP_OP, 0, 0, 0, 0, 0, 0);
    take(e, o);
    total_cnt++;
    if (o.cyc !== e.cyc || o.pc_sel !== 2'd0 || o.retire !== 1'b1)
      $display("FAIL haltreq_wb: cycle %0d sel %0d retire %b, expected cycle %0d sel 0 retire 1",
               o.cyc, o.pc_sel, o.retire, e.cyc);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({halted, mem_req} !== 2'b10) $display("FAIL haltreq_enter: halted/mem_req %b, expected 10", {halted, mem_req});
    else pass_cnt++;
    base = cyc;
    resumereq = 1'b1;
    issue(OP_OPIMM, 0, 0, 0, 0, 0, 0);
    take(e, o);
    total_cnt++;
    if (run_ffetch !== base + 1 || o.cyc !== e.cyc)
      $display("FAIL resume_wins: fetch %0d wb %0d, expected fetch %0d wb %0d", run_ffetch, o.cyc, base + 1, e.cyc);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (halted !== 1'b1) $display("FAIL rehalt: halted %b, expected 1", halted);
    else pass_cnt++;
    haltreq = 1'b0;
    issue(OP_OPIMM, 0, 0, 0, 0, 0, 0);
    resumereq = 1'b0;
    take(e, o);
    total_cnt++;
    if (o.cyc !== e.cyc) $display("FAIL rehalt_resume: cycle %0d, expected %0d", o.cyc, e.cyc);
    else pass_cnt++;
`endif
  endtask

  task automatic test_cause_hold();
    ev_t e, o;
    issue(OP_OP, 0, 0, 0, 0, 0, 0);
    take(e, o);
    total_cnt++;
    if (o.cause !== e.cause) $display("FAIL cause_hold: trap_cause %0d, expected %0d", o.cause, e.cause);
    else pass_cnt++;
    total_cnt++;
    if (o.cyc !== e.cyc) $display("FAIL cause_hold_cycle: cycle %0d, expected %0d", o.cyc, e.cyc);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_fetch();
    ev_t e, o;
    opcode = OP_OPIMM; invalid_inst = 0; ecall = 0; ebreak = 0; branch_taken = 0;
    f_wait = 3;
    tick();
    tick();
    total_cnt++;
    if ({mem_req, mem_ack} !== 2'b10) $display("FAIL rst_mid_setup: mem_req/ack %b, expected 10", {mem_req, mem_ack});
    else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++;
    if (outs !== 15'd0) $display("FAIL rst_mid_outputs: outputs %b, expected all 0", outs);
    else pass_cnt++;
    rst = 1'b0;
    cyc = 0;
    model_cause = 4'd0;
    issue(OP_OPIMM, 0, 0, 0, 0, 0, 0);
    take(e, o);
    total_cnt++;
    if (run_ffetch !== 1) $display("FAIL rst_mid_refetch: cycle %0d, expected 1", run_ffetch);
    else pass_cnt++;
    total_cnt++;
    if (o.cyc !== e.cyc || {o.rf_we, o.pc_sel, o.trap, o.cause, o.retire} !== {e.rf_we, e.pc_sel, e.trap, e.cause, e.retire})
      $display("FAIL rst_mid_wb: cycle %0d fields %b, expected cycle %0d fields %b", o.cyc,
               {o.rf_we, o.pc_sel, o.trap, o.cause, o.retire}, e.cyc, {e.rf_we, e.pc_sel, e.trap, e.cause, e.retire});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_branch_jump();
    test_traps();
    test_cause_hold();
    test_ebreak();
    test_halt_request();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

endmodule
